// File: rtl/pipelined_carry_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_carry_adder_if
// Purpose  : Operand/result bundle for pipelined_carry_adder.
//            Input side : in_valid/in_ready handshake carrying a, b, cin.
//            Output side: out_valid/out_ready handshake carrying sum, carry,
//                         overflow.
// Modports : master - operand source / result consumer
//            slave  - the adder
// Revision : 1.0 - initial release
// ============================================================================
interface pipelined_carry_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, carry, overflow
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, carry, overflow
   );
endinterface
`default_nettype wire

// File: rtl/pipelined_carry_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_carry_adder
// Purpose  : WIDTH-bit adder with carry-in, carry-out and two's-complement
//            overflow, split into CHUNK-bit slices with one pipeline stage per
//            slice and the inter-slice carry registered between stages.
// Ports    : clk - rising-edge clock
//            rst - synchronous active-high reset
//            bus - pipelined_carry_adder_if.slave
//                  in_valid/in_ready/a/b/cin  : operand handshake
//                  out_valid/out_ready/sum/carry/overflow : result handshake
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_carry_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   pipelined_carry_adder_if.slave bus
);
   localparam int STAGES = WIDTH / CHUNK;

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_width
         $fatal(1, "pipelined_carry_adder: WIDTH must be a multiple of CHUNK");
      end
      if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
         $fatal(1, "pipelined_carry_adder: WIDTH/CHUNK must be in 1..16");
      end
   endgenerate

   // Stage registers. Stage k holds the full operands (upper slices ride
   // along), the sum with slices 0..k complete, and the carry out of slice k.
   logic [STAGES-1:0]            r_valid;
   logic [STAGES-1:0][WIDTH-1:0] r_a;
   logic [STAGES-1:0][WIDTH-1:0] r_b;
   logic [STAGES-1:0][WIDTH-1:0] r_sum;
   logic [STAGES-1:0]            r_c;
   logic                         r_ovf;

   // Per-stage inputs (what arrives from the previous stage) and next values.
   logic [STAGES-1:0][WIDTH-1:0] w_a_in;
   logic [STAGES-1:0][WIDTH-1:0] w_b_in;
   logic [STAGES-1:0][WIDTH-1:0] w_sum_in;
   logic [STAGES-1:0]            w_c_in;
   logic [STAGES-1:0]            w_v_in;
   logic [STAGES-1:0][CHUNK:0]   w_slice;
   logic [STAGES-1:0][WIDTH-1:0] w_sum_nx;
   logic                         w_ovf_nx;
   logic                         w_advance;

   // The whole pipe moves as one; it only stalls when a result is waiting
   // at the output and the consumer is not taking it.
   assign w_advance    = !r_valid[STAGES-1] || bus.out_ready;
   assign bus.in_ready = w_advance;

   always_comb begin
      w_a_in   = '0;
      w_b_in   = '0;
      w_sum_in = '0;
      w_c_in   = '0;
      w_v_in   = '0;
      w_slice  = '0;
      w_sum_nx = '0;
      w_ovf_nx = 1'b0;

      w_a_in[0]   = bus.a;
      w_b_in[0]   = bus.b;
      w_c_in[0]   = bus.cin;
      w_v_in[0]   = bus.in_valid;
      w_sum_in[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         w_a_in[k]   = r_a[k-1];
         w_b_in[k]   = r_b[k-1];
         w_c_in[k]   = r_c[k-1];
         w_v_in[k]   = r_valid[k-1];
         w_sum_in[k] = r_sum[k-1];
      end

      for (int k = 0; k < STAGES; k++) begin
         w_slice[k] = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
                    + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, w_c_in[k]};
         w_sum_nx[k] = w_sum_in[k];
         w_sum_nx[k][k*CHUNK +: CHUNK] = w_slice[k][CHUNK-1:0];
      end

      // Carry into the MSB is recovered as a ^ b ^ sum at that bit; overflow
      // is that carry XOR the carry out of the MSB.
      w_ovf_nx = w_a_in[STAGES-1][WIDTH-1] ^ w_b_in[STAGES-1][WIDTH-1]
               ^ w_slice[STAGES-1][CHUNK-1] ^ w_slice[STAGES-1][CHUNK];
   end

   // Data registers load only when a valid item enters a stage, so the output
   // holds its last result while bubbles pass through.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_c     <= '0;
         r_ovf   <= 1'b0;
      end else if (w_advance) begin
         for (int k = 0; k < STAGES; k++) begin
            r_valid[k] <= w_v_in[k];
            if (w_v_in[k]) begin
               r_a[k]   <= w_a_in[k];
               r_b[k]   <= w_b_in[k];
               r_sum[k] <= w_sum_nx[k];
               r_c[k]   <= w_slice[k][CHUNK];
            end
         end
         if (w_v_in[STAGES-1]) begin
            r_ovf <= w_ovf_nx;
         end
      end
   end

   assign bus.out_valid = r_valid[STAGES-1];
   assign bus.sum       = r_sum[STAGES-1];
   assign bus.carry     = r_c[STAGES-1];
   assign bus.overflow  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_pipelined_carry_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_carry_adder
// Purpose  : Self-checking bench for pipelined_carry_adder. A 16-bit/4-stage
//            instance is driven through directed vectors, a backpressured
//            stream and a mid-flight reset; an 8-bit single-stage instance
//            covers the STAGES=1 build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_carry_adder;
   localparam int W  = 16;
   localparam int C  = 4;
   localparam int ST = W / C;

   typedef struct packed {
      logic         o;
      logic         c;
      logic [W-1:0] s;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipelined_carry_adder_if #(.WIDTH(W)) bus ();
   pipelined_carry_adder_if #(.WIDTH(8)) bus1 ();

   pipelined_carry_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   pipelined_carry_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   res_t sb[$];
   res_t sb_e;
   int   n_pass  = 0;
   int   n_total = 0;
   int   n_out   = 0;

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci);
      logic [W:0] full;
      res_t       r;
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      r.s  = full[W-1:0];
      r.c  = full[W];
      r.o  = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Scoreboard: push the model result on every accepted operand, pop and
   // compare on every output transfer.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            n_total++;
            assert (sb.size() != 0) n_pass++;
            else $error("FAIL sb_unexpected: observed output %0h expected none", bus.sum);
            if (sb.size() != 0) begin
               sb_e = sb.pop_front();
               check("sb_result", {14'b0, bus.overflow, bus.carry, bus.sum}, {14'b0, sb_e});
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            sb.push_back(model(bus.a, bus.b, bus.cin));
         end
      end
   end

   task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic [W-1:0] es, input logic ec,
                           input logic eo);
      int lat;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = ci;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, ST);
      check({tag, "_sum"}, {16'b0, bus.sum}, {16'b0, es});
      check({tag, "_carry"}, {31'b0, bus.carry}, {31'b0, ec});
      check({tag, "_overflow"}, {31'b0, bus.overflow}, {31'b0, eo});
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] va[8];
      logic [W-1:0] vb[8];
      logic         vc[8];
      logic [31:0]  held;
      int           idx, guard, stall_cnt, out_before;
      logic         stall_started, acc;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b1;
      bus1.in_valid = 1'b0;
      bus1.a        = '0;
      bus1.b        = '0;
      bus1.cin      = 1'b0;
      bus1.out_ready= 1'b1;
      held          = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'b0, bus.out_valid}, 0);
      check("rst_sum", {16'b0, bus.sum}, 0);
      check("rst_carry", {31'b0, bus.carry}, 0);
      check("rst_overflow", {31'b0, bus.overflow}, 0);
      check("rst_in_ready", {31'b0, bus.in_ready}, 1);
      check("rst_s1_out_valid", {31'b0, bus1.out_valid}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed vectors
      directed("basic",    16'h1234, 16'h0F0F, 1'b0, 16'h2143, 1'b0, 1'b0);
      directed("ripple",   16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
      directed("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      directed("ovf_neg",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

      // Back-to-back stream with a 3-cycle output stall
      for (int i = 0; i < 8; i++) begin
         va[i] = W'($urandom);
         vb[i] = W'($urandom);
         vc[i] = 1'($urandom);
      end
      out_before    = n_out;
      idx           = 0;
      guard         = 0;
      stall_cnt     = 0;
      stall_started = 1'b0;
      while ((idx < 8 || stall_cnt > 0 || !stall_started) && guard < 200) begin
         bus.in_valid = (idx < 8);
         if (idx < 8) begin
            bus.a   = va[idx];
            bus.b   = vb[idx];
            bus.cin = vc[idx];
         end
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         if (stall_cnt > 0) begin
            check("stall_in_ready", {31'b0, bus.in_ready}, 0);
            check("stall_out_valid", {31'b0, bus.out_valid}, 1);
            check("stall_hold", {14'b0, bus.overflow, bus.carry, bus.sum}, held);
         end
         @(posedge clk); #1;
         guard++;
         if (acc) idx++;
         if (!stall_started && bus.out_valid) begin
            stall_started = 1'b1;
            stall_cnt     = 3;
            held          = {14'b0, bus.overflow, bus.carry, bus.sum};
            bus.out_ready = 1'b0;
         end else if (stall_cnt > 0) begin
            stall_cnt--;
            if (stall_cnt == 0) bus.out_ready = 1'b1;
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("stream_accepted", idx, 8);
      guard = 0;
      while (sb.size() != 0 && guard < 30) begin
         @(posedge clk); #1;
         guard++;
      end
      repeat (2) @(posedge clk);
      #1;
      check("stream_drain", sb.size(), 0);
      check("stream_count", n_out - out_before, 8);

      // Reset while three results are in flight
      out_before = n_out;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.a        = 16'h1111 * 16'(i + 1);
         bus.b        = 16'h0F0F;
         bus.cin      = 1'b1;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      rst          = 1'b1;
      @(posedge clk); #1;
      rst          = 1'b0;
      @(negedge clk);
      check("flush_out_valid", {31'b0, bus.out_valid}, 0);
      check("flush_sum", {16'b0, bus.sum}, 0);
      check("flush_carry", {31'b0, bus.carry}, 0);
      check("flush_overflow", {31'b0, bus.overflow}, 0);
      repeat (6) @(posedge clk);
      #1;
      check("flush_no_output", n_out - out_before, 0);
      directed("post_reset", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

      // Single-stage build
      bus1.a        = 8'hC8;
      bus1.b        = 8'h64;
      bus1.cin      = 1'b1;
      bus1.in_valid = 1'b1;
      @(negedge clk);
      check("s1_in_ready", {31'b0, bus1.in_ready}, 1);
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      check("s1_out_valid", {31'b0, bus1.out_valid}, 1);
      check("s1_sum", {24'b0, bus1.sum}, 32'h2D);
      check("s1_carry", {31'b0, bus1.carry}, 1);
      check("s1_overflow", {31'b0, bus1.overflow}, 0);
      @(posedge clk); #1;
      check("s1_bubble_valid", {31'b0, bus1.out_valid}, 0);
      check("s1_sum_retained", {24'b0, bus1.sum}, 32'h2D);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
